// File: rtl/aes_stream_ctrl_pkg.sv
// Shared types, command codes and helpers for the AES stream controller.
// Optional CBC chaining is enabled by defining CBC_CHAIN_EN.
package aes_stream_ctrl_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BLK_W         = 128;
   localparam int unsigned WORDS_PER_BLK = 4;
   localparam logic [1:0]  LAST_WORD     = 2'(WORDS_PER_BLK - 1);

   localparam logic [WORD_W-1:0] CMD_SET_KEY_128     = 32'h0000_0001;
   localparam logic [WORD_W-1:0] CMD_ECB_ENCRYPT_128 = 32'h0000_0010;
   localparam logic [WORD_W-1:0] CMD_ECB_DECRYPT_128 = 32'h0000_0011;
   localparam logic [WORD_W-1:0] CMD_CBC_ENCRYPT_128 = 32'h0000_0020;
   localparam logic [WORD_W-1:0] CMD_CBC_DECRYPT_128 = 32'h0000_0021;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_KEY,
      S_GET_IV,
      S_GET_BLK,
      S_START,
      S_WAIT,
      S_SEND,
      S_DRAIN
   } state_e;

   typedef enum logic [2:0] {
      K_KEY,
      K_ECB,
      K_CBC_ENC,
      K_CBC_DEC,
      K_UNKNOWN
   } cmd_kind_e;

   // CBC codes only decode as CBC when chaining is built in; otherwise they drain.
   function automatic cmd_kind_e decode_cmd(input logic [WORD_W-1:0] cmd);
      cmd_kind_e kind;
      case (cmd)
         CMD_SET_KEY_128:     kind = K_KEY;
         CMD_ECB_ENCRYPT_128: kind = K_ECB;
         CMD_ECB_DECRYPT_128: kind = K_ECB;
`ifdef CBC_CHAIN_EN
         CMD_CBC_ENCRYPT_128: kind = K_CBC_ENC;
         CMD_CBC_DECRYPT_128: kind = K_CBC_DEC;
`endif
         default:             kind = K_UNKNOWN;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/aes_stream_ctrl_serializer.sv
// aes_blk_serializer: loads a 128-bit block and shifts it out MSB word first
// on a 32-bit AXI-Stream, tagging the 4th word with tlast when requested.
module aes_blk_serializer
   import aes_stream_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [BLK_W-1:0]  blk_i,
   input  logic              last_i,
   output logic [WORD_W-1:0] tdata_o,
   output logic              tvalid_o,
   input  logic              tready_i,
   output logic              tlast_o,
   output logic              done_o
);

   logic [BLK_W-1:0] shift_q, shift_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             fire;

   assign fire = valid_q & tready_i;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (load_i) begin
         shift_d = blk_i;
         cnt_d   = '0;
         valid_d = 1'b1;
         last_d  = last_i;
      end else if (fire) begin
         shift_d = shift_q << WORD_W;
         cnt_d   = cnt_q + 2'd1;
         if (cnt_q == LAST_WORD) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign tdata_o  = shift_q[BLK_W-1 -: WORD_W];
   assign tvalid_o = valid_q;
   assign tlast_o  = valid_q & last_q & (cnt_q == LAST_WORD);
   assign done_o   = fire & (cnt_q == LAST_WORD);

endmodule

// File: rtl/aes_stream_ctrl.sv
// AXI-Stream initiator for aes_top: deserializes command packets, sequences
// en/en_o handshakes and serializes results. CBC chaining under CBC_CHAIN_EN.
module aes_stream_ctrl
   import aes_stream_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [WORD_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              aes_en,
   output logic [WORD_W-1:0] aes_cmd,
   output logic [BLK_W-1:0]  aes_key,
   output logic [BLK_W-1:0]  aes_in_blk,
   input  logic [BLK_W-1:0]  aes_out_blk,
   input  logic              aes_en_o,
   output logic              err
);

   localparam int unsigned WAIT_W = $clog2(WAIT_TIMEOUT + 1);

   state_e              state_q, state_d;
   cmd_kind_e           kind_q, kind_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [BLK_W-1:0]    data_q, data_d;
   logic [BLK_W-1:0]    key_q, key_d;
   logic [WORD_W-1:0]   cmd_q, cmd_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                last_q, last_d;
   logic                drain_err_q, drain_err_d;
   logic                err_q, err_d;
   logic                alive_q;
   logic                acc;
   logic                ser_load, ser_done;
   logic [BLK_W-1:0]    res_blk;
`ifdef CBC_CHAIN_EN
   logic [BLK_W-1:0]    chain_q, chain_d;

   assign res_blk    = (kind_q == K_CBC_DEC) ? (aes_out_blk ^ chain_q) : aes_out_blk;
   assign aes_in_blk = data_q ^ ((kind_q == K_CBC_ENC) ? chain_q : '0);
`else
   assign res_blk    = aes_out_blk;
   assign aes_in_blk = data_q;
`endif

   assign acc = s_tvalid & s_tready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      key_d       = key_q;
      cmd_d       = cmd_q;
      wait_d      = wait_q;
      last_d      = last_q;
      drain_err_d = drain_err_q;
      err_d       = 1'b0;
      ser_load    = 1'b0;
`ifdef CBC_CHAIN_EN
      chain_d     = chain_q;
`endif
      case (state_q)
         S_IDLE: if (acc) begin
            cmd_d  = s_tdata;
            kind_d = decode_cmd(s_tdata);
            last_d = 1'b0;
            if (!s_tlast) begin
               case (decode_cmd(s_tdata))
                  K_KEY:                state_d = S_GET_KEY;
                  K_ECB:                state_d = S_GET_BLK;
                  K_CBC_ENC, K_CBC_DEC: state_d = S_GET_IV;
                  default: begin
                     state_d     = S_DRAIN;
                     drain_err_d = 1'b1;
                  end
               endcase
            end
         end
         S_GET_KEY, S_GET_IV, S_GET_BLK: if (acc) begin
            data_d = {data_q[BLK_W-WORD_W-1:0], s_tdata};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == LAST_WORD) begin
               case (state_q)
                  S_GET_KEY: begin
                     key_d   = data_d;
                     state_d = S_START;
                  end
                  S_GET_IV: begin
`ifdef CBC_CHAIN_EN
                     chain_d = data_d;
`endif
                     state_d = s_tlast ? S_IDLE : S_GET_BLK;
                  end
                  default: begin
                     last_d  = s_tlast;
                     state_d = S_START;
                  end
               endcase
            end else if (s_tlast) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_START: begin
            wait_d  = WAIT_W'(1);
            state_d = S_WAIT;
         end
         // wait_q counts cycles since the en pulse; err lands exactly WAIT_TIMEOUT after it.
         S_WAIT: begin
            if (aes_en_o) begin
               if (kind_q == K_KEY) begin
                  state_d = S_IDLE;
               end else begin
                  ser_load = 1'b1;
                  state_d  = S_SEND;
`ifdef CBC_CHAIN_EN
                  if (kind_q == K_CBC_ENC) chain_d = aes_out_blk;
                  if (kind_q == K_CBC_DEC) chain_d = data_q;
`endif
               end
            end else if (wait_q >= WAIT_W'(WAIT_TIMEOUT - 1)) begin
               err_d       = 1'b1;
               drain_err_d = 1'b0;
               state_d     = last_q ? S_IDLE : S_DRAIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_SEND: if (ser_done) state_d = last_q ? S_IDLE : S_GET_BLK;
         S_DRAIN: if (acc && s_tlast) begin
            err_d   = drain_err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_comb begin
      s_tready = 1'b0;
      aes_en   = 1'b0;
      case (state_q)
         S_IDLE, S_GET_KEY, S_GET_IV, S_GET_BLK, S_DRAIN: s_tready = alive_q;
         S_START:                                         aes_en   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kind_q      <= K_UNKNOWN;
         cnt_q       <= '0;
         data_q      <= '0;
         key_q       <= '0;
         cmd_q       <= '0;
         wait_q      <= '0;
         last_q      <= 1'b0;
         drain_err_q <= 1'b0;
         err_q       <= 1'b0;
         alive_q     <= 1'b0;
`ifdef CBC_CHAIN_EN
         chain_q     <= '0;
`endif
      end else begin
         kind_q      <= kind_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         key_q       <= key_d;
         cmd_q       <= cmd_d;
         wait_q      <= wait_d;
         last_q      <= last_d;
         drain_err_q <= drain_err_d;
         err_q       <= err_d;
         alive_q     <= 1'b1;
`ifdef CBC_CHAIN_EN
         chain_q     <= chain_d;
`endif
      end
   end

   aes_blk_serializer u_ser (
      .clk_i    (clk),
      .rst_ni   (reset),
      .load_i   (ser_load),
      .blk_i    (res_blk),
      .last_i   (last_q),
      .tdata_o  (m_tdata),
      .tvalid_o (m_tvalid),
      .tready_i (m_tready),
      .tlast_o  (m_tlast),
      .done_o   (ser_done)
   );

   assign aes_cmd = cmd_q;
   assign aes_key = key_q;
   assign err     = err_q;

endmodule
